// File: rtl/cnn_seq_ctrl.sv
// cnn_seq_ctrl: frame sequencer for the CNN / capacity-mask datapath.
// Ports:
//   clk, rst_n                       clock, synchronous active-low reset
//   in_valid, task_number, mode      input beat stream, header on beat 0
//   img/ker/wb/cap _we, _addr        buffer write strobes and addresses
//   cfg_task, cfg_mode               latched frame configuration
//   dp_start, dp_done                datapath start pulse / completion
//   res_sel, res_data                result word select and read data
//   out_valid, out                   serialised result beats
//   busy, err_proto, err_timeout     status and error pulses
module cnn_seq_ctrl #(
    parameter int IMG_LEN_T0 = 72,
    parameter int IMG_LEN_T1 = 36,
    parameter int KER_LEN    = 18,
    parameter int WB_LEN     = 57,
    parameter int CAP_LEN    = 5,
    parameter int LAT_LIMIT  = 150
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic        task_number,
    input  logic [1:0]  mode,
    output logic        img_we,
    output logic [6:0]  img_addr,
    output logic        ker_we,
    output logic [4:0]  ker_addr,
    output logic        wb_we,
    output logic [5:0]  wb_addr,
    output logic        cap_we,
    output logic [2:0]  cap_addr,
    output logic        cfg_task,
    output logic [1:0]  cfg_mode,
    output logic        dp_start,
    input  logic        dp_done,
    output logic [1:0]  res_sel,
    input  logic [31:0] res_data,
    output logic        out_valid,
    output logic [31:0] out,
    output logic        busy,
    output logic        err_proto,
    output logic        err_timeout
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WAIT_DP,
        OUT
    } state_t;

    localparam int WDW = $clog2(LAT_LIMIT + 1);
    localparam logic [WDW-1:0] WD_MAX = WDW'(LAT_LIMIT);

    state_t          state_q, state_d;
    logic [6:0]      idx_q, idx_d;
    logic            cfg_task_q, cfg_task_d;
    logic [1:0]      cfg_mode_q, cfg_mode_d;
    logic            dp_start_q, dp_start_d;
    logic [WDW-1:0]  wd_q, wd_d;
    logic [1:0]      beat_q, beat_d;
    logic [31:0]     out_q, out_d;
    logic            out_valid_q, out_valid_d;

    logic            accept;
    logic            eff_task;
    logic [6:0]      last_idx;
    logic [1:0]      n_beats;

    // Header is only valid on the first beat, so IDLE looks at the
    // live input while later states use the latched copy.
    assign eff_task = (state_q == IDLE) ? task_number : cfg_task_q;
    assign last_idx = eff_task ? 7'(IMG_LEN_T1 - 1)
                               : 7'(IMG_LEN_T0 - 1);
    assign n_beats  = cfg_task_q ? 2'd1 : 2'd3;
    assign accept   = in_valid
                   && (state_q == IDLE || state_q == LOAD);

    assign img_we   = accept;
    assign ker_we   = accept && (idx_q < 7'(KER_LEN));
    assign wb_we    = accept && !eff_task
                   && (idx_q < 7'(WB_LEN));
    assign cap_we   = accept && eff_task
                   && (idx_q < 7'(CAP_LEN));

    assign img_addr = idx_q;
    assign ker_addr = idx_q[4:0];
    assign wb_addr  = idx_q[5:0];
    assign cap_addr = idx_q[2:0];

    assign cfg_task  = cfg_task_q;
    assign cfg_mode  = cfg_mode_q;
    assign dp_start  = dp_start_q;
    assign out_valid = out_valid_q;
    assign out       = out_q;
    assign busy      = (state_q != IDLE);
    assign res_sel   = (state_q == OUT) ? beat_q : 2'd0;

    always_comb begin
        err_proto   = 1'b0;
        err_timeout = 1'b0;
        unique case (state_q)
            LOAD:    err_proto = !in_valid;
            WAIT_DP: begin
                err_proto   = in_valid;
                err_timeout = !dp_done && (wd_q == WD_MAX);
            end
            OUT:     err_proto = in_valid;
            default: ;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cfg_task_d  = cfg_task_q;
        cfg_mode_d  = cfg_mode_q;
        dp_start_d  = 1'b0;
        wd_d        = wd_q;
        beat_d      = beat_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        unique case (state_q)
            IDLE: begin
                idx_d = 7'd0;
                if (in_valid) begin
                    cfg_task_d = task_number;
                    cfg_mode_d = mode;
                    idx_d      = 7'd1;
                    state_d    = LOAD;
                end
            end
            LOAD: begin
                if (!in_valid) begin
                    idx_d   = 7'd0;
                    state_d = IDLE;
                end else if (idx_q == last_idx) begin
                    idx_d      = 7'd0;
                    wd_d       = '0;
                    dp_start_d = 1'b1;
                    state_d    = WAIT_DP;
                end else begin
                    idx_d = idx_q + 7'd1;
                end
            end
            WAIT_DP: begin
                wd_d = wd_q + 1'b1;
                // dp_done takes priority over the watchdog limit.
                if (dp_done) begin
                    out_d       = res_data;
                    out_valid_d = 1'b1;
                    beat_d      = 2'd1;
                    state_d     = OUT;
                end else if (wd_q == WD_MAX) begin
                    wd_d    = '0;
                    state_d = IDLE;
                end
            end
            OUT: begin
                if (beat_q == n_beats) begin
                    out_d       = 32'd0;
                    out_valid_d = 1'b0;
                    beat_d      = 2'd0;
                    state_d     = IDLE;
                end else begin
                    out_d  = res_data;
                    beat_d = beat_q + 2'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= 7'd0;
            cfg_task_q  <= 1'b0;
            cfg_mode_q  <= 2'd0;
            dp_start_q  <= 1'b0;
            wd_q        <= '0;
            beat_q      <= 2'd0;
            out_q       <= 32'd0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cfg_task_q  <= cfg_task_d;
            cfg_mode_q  <= cfg_mode_d;
            dp_start_q  <= dp_start_d;
            wd_q        <= wd_d;
            beat_q      <= beat_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_cnn_seq_ctrl.sv
// tb_cnn_seq_ctrl: directed + randomized frame-level checks of
// cnn_seq_ctrl against a per-frame expected timeline.
module tb_cnn_seq_ctrl;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        task_number;
    logic [1:0]  mode;
    logic        img_we, ker_we, wb_we, cap_we;
    logic [6:0]  img_addr;
    logic [4:0]  ker_addr;
    logic [5:0]  wb_addr;
    logic [2:0]  cap_addr;
    logic        cfg_task;
    logic [1:0]  cfg_mode;
    logic        dp_start;
    logic        dp_done;
    logic [1:0]  res_sel;
    logic [31:0] res_data;
    logic        out_valid;
    logic [31:0] out;
    logic        busy, err_proto, err_timeout;

    logic [31:0] res_arr [4];
    assign res_data = res_arr[res_sel];

    int ncmp = 0;
    int nfail = 0;

    // expected values for the current cycle
    bit          e_img, e_ker, e_wb, e_cap;
    bit          e_start, e_ov, e_busy, e_ep, e_et;
    bit          chk_addr;
    logic [6:0]  e_addr;
    logic [1:0]  e_sel;
    logic [31:0] e_out;
    logic        mc_t;
    logic [1:0]  mc_m;

    cnn_seq_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .task_number(task_number),
        .mode(mode),
        .img_we(img_we), .img_addr(img_addr),
        .ker_we(ker_we), .ker_addr(ker_addr),
        .wb_we(wb_we), .wb_addr(wb_addr),
        .cap_we(cap_we), .cap_addr(cap_addr),
        .cfg_task(cfg_task), .cfg_mode(cfg_mode),
        .dp_start(dp_start), .dp_done(dp_done),
        .res_sel(res_sel), .res_data(res_data),
        .out_valid(out_valid), .out(out),
        .busy(busy), .err_proto(err_proto),
        .err_timeout(err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(string tag, logic [31:0] obs,
                       logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%h expected=%h",
                   tag, obs, exp);
        end
    endtask

    task automatic exp_idle();
        e_img = 0; e_ker = 0; e_wb = 0; e_cap = 0;
        e_start = 0; e_ov = 0; e_busy = 0;
        e_ep = 0; e_et = 0; chk_addr = 0;
        e_addr = '0; e_sel = '0; e_out = '0;
    endtask

    // check this cycle, then advance to 1 time unit past next posedge
    task automatic step();
        #2;
        chk("img_we", img_we, e_img);
        chk("ker_we", ker_we, e_ker);
        chk("wb_we", wb_we, e_wb);
        chk("cap_we", cap_we, e_cap);
        chk("dp_start", dp_start, e_start);
        chk("out_valid", out_valid, e_ov);
        chk("out", out, e_out);
        chk("busy", busy, e_busy);
        chk("err_proto", err_proto, e_ep);
        chk("err_timeout", err_timeout, e_et);
        chk("res_sel", res_sel, e_sel);
        chk("cfg_task", cfg_task, mc_t);
        chk("cfg_mode", cfg_mode, mc_m);
        if (chk_addr) begin
            chk("img_addr", img_addr, e_addr);
            chk("ker_addr", ker_addr, e_addr[4:0]);
            chk("wb_addr", wb_addr, e_addr[5:0]);
            chk("cap_addr", cap_addr, e_addr[2:0]);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) begin
            exp_idle();
            in_valid = 0;
            task_number = 1'($urandom);
            mode = 2'($urandom);
            dp_done = 1'($urandom);
            step();
        end
        dp_done = 0;
    endtask

    task automatic set_res(logic [31:0] a, logic [31:0] b,
                           logic [31:0] c);
        res_arr[0] = a;
        res_arr[1] = b;
        res_arr[2] = c;
        res_arr[3] = $urandom;
    endtask

    task automatic rand_res();
        set_res($urandom, $urandom, $urandom);
    endtask

    // nb: beats sent; lat: dp_done delay after dp_start (<0: never)
    // gap: WAIT_DP cycle with a stray in_valid (<0: none)
    // rst_beat: output beat during which reset is pulsed (0: none)
    task automatic frame(bit t, logic [1:0] m, int nb, int lat,
                         int gap, int rst_beat);
        int len;
        int nout;
        int lim;
        len  = t ? 36 : 72;
        nout = t ? 1 : 3;
        for (int k = 0; k < nb; k++) begin
            exp_idle();
            in_valid = 1;
            task_number = (k == 0) ? t : 1'($urandom);
            mode = (k == 0) ? m : 2'($urandom);
            dp_done = 1'($urandom);
            e_img = 1;
            e_ker = (k < 18);
            e_wb = !t && (k < 57);
            e_cap = t && (k < 5);
            e_busy = (k > 0);
            chk_addr = 1;
            e_addr = 7'(k);
            step();
            if (k == 0) begin
                mc_t = t;
                mc_m = m;
            end
        end
        dp_done = 0;
        if (nb < len) begin
            exp_idle();
            in_valid = 0;
            e_busy = 1;
            e_ep = 1;
            step();
            exp_idle();
            step();
            return;
        end
        lim = (lat < 0) ? 150 : lat;
        for (int d = 0; d <= lim; d++) begin
            exp_idle();
            e_busy = 1;
            e_start = (d == 0);
            in_valid = (d == gap);
            task_number = 1'($urandom);
            mode = 2'($urandom);
            e_ep = (d == gap);
            dp_done = (lat >= 0 && d == lat);
            e_et = (lat < 0 && d == 150);
            step();
        end
        in_valid = 0;
        dp_done = 0;
        if (lat < 0) begin
            exp_idle();
            step();
            return;
        end
        for (int j = 1; j <= nout; j++) begin
            exp_idle();
            e_busy = 1;
            e_ov = 1;
            e_out = res_arr[j-1];
            e_sel = 2'(j);
            dp_done = 1'($urandom);
            if (j == rst_beat) rst_n = 0;
            step();
            if (j == rst_beat) begin
                rst_n = 1;
                mc_t = 0;
                mc_m = 0;
                dp_done = 0;
                exp_idle();
                step();
                return;
            end
        end
        dp_done = 0;
    endtask

    initial begin
        rst_n = 0;
        in_valid = 0;
        task_number = 0;
        mode = 0;
        dp_done = 0;
        mc_t = 0;
        mc_m = 0;
        set_res(0, 0, 0);
        @(posedge clk);
        #1;
        exp_idle();
        step();
        rst_n = 1;
        idle(2);

        set_res(32'h3F800000, 32'h40000000, 32'h40400000);
        frame(0, 2'd2, 72, 10, -1, 0);
        idle(1);

        set_res(32'h0000001A, 32'h0, 32'h0);
        frame(1, 2'd1, 36, 7, -1, 0);
        idle(1);

        rand_res();
        frame(0, 2'd0, 21, 10, -1, 0);
        frame(0, 2'd3, 72, 12, -1, 0);

        rand_res();
        frame(1, 2'd2, 36, -1, -1, 0);
        idle(1);

        rand_res();
        frame(0, 2'd1, 72, 5, -1, 2);
        rand_res();
        frame(1, 2'd3, 36, 3, -1, 0);

        rand_res();
        frame(0, 2'd3, 72, 20, 7, 0);
        rand_res();
        frame(1, 2'd0, 36, 150, -1, 0);
        rand_res();
        frame(0, 2'd2, 72, 0, -1, 0);

        for (int i = 0; i < 6; i++) begin
            bit t;
            int lat;
            int gap;
            t = 1'($urandom);
            lat = $urandom_range(0, 150);
            gap = (lat > 1) ? $urandom_range(1, lat - 1) : -1;
            rand_res();
            frame(t, 2'($urandom), t ? 36 : 72, lat, gap, 0);
            if ($urandom_range(0, 1) == 1) idle(1);
        end
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 ncmp, nfail);
        $finish;
    end

endmodule

// File: doc/cnn_seq_ctrl.md
Name: cnn_seq_ctrl

Overview:
Top-level sequencer for the CNN / capacity-mask datapath. It decodes the per-frame header (task_number, mode) and counts streamed input beats. It generates write enables and addresses for the image, kernel, weight/bias and capacity buffers, starts the datapath and bounds its latency. It then serialises results onto out/out_valid: 3 beats for task 0, 1 beat for task 1.

Parameters:
IMG_LEN_T0, 72, frame length (image beats) for task 0
IMG_LEN_T1, 36, frame length (image beats) for task 1
KER_LEN, 18, kernel beats per frame (both channels)
WB_LEN, 57, weight/bias beats (task 0 only)
CAP_LEN, 5, capacity_cost beats (task 1 only)
LAT_LIMIT, 150, max cycles from dp_start to dp_done

Ports:
clk  in  1  single clock, all logic on posedge
rst_n  in  1  reset, synchronous, active-low
in_valid  in  1  input beat valid
task_number  in  1  task select; valid on first beat only
mode  in  2  mode; valid on first beat only
img_we  out  1  image buffer write enable
img_addr  out  7  image buffer address
ker_we  out  1  kernel buffer write enable (ch1 and ch2)
ker_addr  out  5  kernel buffer address
wb_we  out  1  weight/bias buffer write enable
wb_addr  out  6  weight/bias buffer address
cap_we  out  1  capacity buffer write enable
cap_addr  out  3  capacity buffer address
cfg_task  out  1  latched task for the datapath
cfg_mode  out  2  latched mode for the datapath
dp_start  out  1  one-cycle start pulse
dp_done  in  1  datapath finished; results held stable until next dp_start
res_sel  out  2  result index presented to the datapath
res_data  in  32  selected result word, combinational from res_sel
out_valid  out  1  output beat valid
out  out  32  output data
busy  out  1  high in any state other than IDLE
err_proto  out  1  one-cycle pulse on a protocol violation
err_timeout  out  1  one-cycle pulse on a latency overrun

Behaviour:
- Reset: synchronous. rst_n=0 at a posedge forces IDLE; all counters, cfg_task, cfg_mode, out_valid, out, dp_start, err_* become 0. Reset applies in any state, including mid-frame and mid-output.
- States: IDLE, LOAD, WAIT_DP, OUT.
- idx counter: 7 bits, 0 in IDLE. Addresses are combinational: img_addr=idx, ker_addr=idx[4:0], wb_addr=idx[5:0], cap_addr=idx[2:0].
- Effective task: task_number in IDLE, cfg_task in LOAD. L = IMG_LEN_T0 if task 0, IMG_LEN_T1 if task 1.
- Write enables (combinational; asserted only when in_valid=1 and state is IDLE or LOAD):
  - img_we: always.
  - ker_we: idx<KER_LEN.
  - wb_we: task 0 and idx<WB_LEN.
  - cap_we: task 1 and idx<CAP_LEN.
- IDLE: on in_valid=1, latch cfg_task<=task_number and cfg_mode<=mode, set idx<=1, go to LOAD.
- LOAD:
  - in_valid=1 and idx<L-1: idx++.
  - in_valid=1 and idx=L-1: last beat; go to WAIT_DP; dp_start=1 for the following cycle only.
  - in_valid=0 before the last beat: err_proto pulse, return to IDLE, no dp_start.
- WAIT_DP:
  - Watchdog counts from 1 on the cycle after dp_start.
  - dp_done=1: register out<=res_data (res_sel=0), out_valid<=1, beat<=1, go to OUT.
  - Watchdog reaches LAT_LIMIT with no dp_done: err_timeout pulse, go to IDLE, no output.
  - dp_done and watchdog limit in the same cycle: dp_done wins.
- OUT:
  - res_sel=beat. N=3 for task 0, N=1 for task 1.
  - beat<N: out<=res_data, beat++.
  - beat=N: out_valid<=0, out<=0, go to IDLE.
  - out_valid is therefore high exactly N consecutive cycles, starting the cycle after dp_done is sampled.
- dp_done is ignored outside WAIT_DP.
- in_valid=1 in WAIT_DP or OUT: err_proto pulse; the beat is ignored and no write enable fires.
- out is 0 whenever out_valid=0. out_valid is never high in the same cycle in_valid is accepted.
- A new frame is accepted in IDLE on the first cycle after out_valid falls.
- res_sel=0 in all states except OUT.

Test Plan:
1. Task 0 frame, mode 2, 72 beats:
   - img_we high 72 cycles, addr 0..71; ker_we addr 0..17; wb_we addr 0..56; cap_we never.
   - cfg_task=0, cfg_mode=2; single dp_start the cycle after beat 71.
   - dp_done 10 cycles later with res 3F800000/40000000/40400000 -> out_valid for 3 cycles with those exact words, then out_valid=0 and out=0.
2. Task 1 frame, mode 1, 36 beats, cap 3,1,4,1,5:
   - cap_we addr 0..4; wb_we never.
   - dp_done with res 0000001A -> out_valid for 1 cycle, out=0000001A.
3. Task 0 frame with in_valid dropped after beat 20 -> err_proto pulse, busy=0 next cycle, no dp_start; the following full frame completes normally.
4. Task 1 frame, dp_done never asserted -> err_timeout pulse exactly 150 cycles after dp_start, out_valid stays 0, return to IDLE.
5. rst_n=0 for 1 cycle during the second output beat of task 0 -> next cycle out_valid=0, out=0, state IDLE, cfg_* =0; the next frame passes.
6. in_valid pulsed during WAIT_DP -> err_proto pulse, no *_we; a new frame issued 1 cycle after out_valid falls is accepted with correct addresses.
